fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters:
  - the display pixel fetch path, which has strict priority and is never stalled;
  - a writer (camera/CPU) with a valid/ready handshake.
- Sits between the VGA timing/decoder logic and the framebuffer BRAM, on the system clock.
- Writes pass through a 1-entry holding buffer and drain into idle RAM cycles.
- A sticky flag reports write starvation.

Parameters:
- ADDR_W, 17, framebuffer address width (320x240 = 76800 words).
- DATA_W, 12, pixel width (4:4:4 RGB).
- RD_LAT, 1, RAM read latency in clk cycles (1..3).
- STARVE_MAX, 15, consecutive blocked cycles with full buffer before starve_flag sets (4-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- rd_req  in  1  display fetch request; at most one pulse per 2 clks
- rd_addr  in  ADDR_W  fetch address, sampled with rd_req
- rd_valid_o  out  1  fetched pixel valid, 1-cycle pulse
- rd_data_o  out  DATA_W  fetched pixel
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  buffer can accept
- vblank  in  1  vertical blanking indicator from timing logic
- starve_clr  in  1  clears starve_flag
- starve_flag  out  1  sticky starvation indicator
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset values: all outputs 0 except wr_ready = 1. Buffer empty, state IDLE, counters 0.
- Slot FSM, registered, evaluated each edge. The state names what the RAM port is driven with during the following cycle.
  - RD if rd_req = 1 (wins unconditionally).
  - Else WR if the buffer is full (and the drain condition holds).
  - Else IDLE.
- RD: mem_en = 1, mem_we = 0, mem_addr = rd_addr as sampled at that edge.
- WR: mem_en = 1, mem_we = 1, mem_addr/mem_wdata from the buffer. The buffer empties at the same edge that enters WR.
- IDLE: mem_en = 0, mem_we = 0. mem_addr/mem_wdata hold their last values.
- Read latency:
  - rd_valid pipeline of depth RD_LAT+2.
  - rd_req sampled at edge T gives rd_valid_o = 1 in the cycle after edge T+RD_LAT+1 (3 clks for RD_LAT = 1).
  - rd_data_o is mem_rdata registered at edge T+RD_LAT+1; it holds between pulses.
- Write handshake:
  - wr_ready = ~buffer_full, driven from a register with no combinational path from any input.
  - Transfer occurs when wr_valid & wr_ready at an edge; the buffer captures addr/data.
  - A full buffer does not accept in the cycle it drains. Max write throughput is 1 per 2 clks.
  - wr_valid may drop without a transfer; no side effects.
- Simultaneous rd_req and full buffer: read granted, write waits. No limit on consecutive reads.
- Starvation:
  - 4-bit counter increments each edge where the buffer is full and not drained; it resets to 0 on drain.
  - When the counter reaches STARVE_MAX, starve_flag is set. It stays set until starve_clr or reset.
  - starve_clr and a set condition at the same edge: set wins.
- Reset mid-operation: buffered write discarded; in-flight rd_valid pulses are dropped; mem_en deasserts asynchronously.
- Address/width: no arithmetic on addresses; pass-through only. Out-of-range addresses are the caller's responsibility.

Optional Feature:
- Macro: FB_VBLANK_WR_ONLY_EN.
- Defined:
  - The buffer drains only at edges where vblank = 1 and rd_req = 0.
  - The starvation counter advances only while vblank = 1. Blocking during active video is expected and does not count.
- Undefined:
  - vblank is ignored; the buffer drains in any cycle without rd_req.

Test Plan:
- Reset then single read: rd_req = 1, rd_addr = 0x00123 at edge 5 -> mem_en = 1, we = 0, addr = 0x00123 after edge 5. RAM returns 0xABC; rd_valid_o pulse after edge 7 with rd_data_o = 0xABC.
- Single write, no reads: wr_valid with addr = 0x00010, data = 0x0F0 accepted at edge 3 -> wr_ready = 0 after edge 3. mem_we = 1 with addr 0x00010 / data 0x0F0 after edge 4; wr_ready = 1 after edge 4.
- Read priority: buffer full, rd_req at edges 10 and 12 -> RD slots after edges 10 and 12, WR slot after edge 11; the write is never lost.
- Starvation: buffer full, rd_req held high 20 edges (bench violates spacing) -> starve_flag = 1 after the 15th blocked edge. It stays 1 after the reads stop; starve_clr pulse -> 0.
- Back-to-back writes with wr_valid held for 4 writes, no reads -> accepts at edges 1, 3, 5, 7; 4 WR slots with data order preserved.
- Reset asserted one cycle after rd_req -> no rd_valid_o pulse, buffer empty, wr_ready = 1. With FB_VBLANK_WR_ONLY_EN, vblank = 0 -> write stays buffered until vblank = 1.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares one single-port framebuffer RAM between the display fetch (strict priority)
// and a buffered writer. Optional build macro FB_VBLANK_WR_ONLY_EN limits write drains to vertical blanking.
module fb_access_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              vblank,
  input  logic              starve_clr,
  output logic              starve_flag,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // State encoding doubles as {mem_en, mem_we} for the cycle that follows the edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b10,
    ST_WR   = 2'b11
  } slot_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);
  localparam logic [3:0] CNT_SAT    = 4'hF;

  slot_e             state_r;
  slot_e             state_nxt_s;
  logic              buf_full_r;
  logic [ADDR_W-1:0] buf_addr_r;
  logic [DATA_W-1:0] buf_data_r;
  logic [3:0]        starve_cnt_r;
  logic [RD_LAT:0]   rd_pipe_r;
  logic              drain_s;
  logic              accept_s;
  logic              blocked_s;
  logic              starve_set_s;

`ifdef FB_VBLANK_WR_ONLY_EN
  assign drain_s   = buf_full_r & ~rd_req & vblank;
  assign blocked_s = buf_full_r & ~drain_s & vblank;
`else
  logic unused_vblank_s;
  assign unused_vblank_s = vblank;
  assign drain_s   = buf_full_r & ~rd_req;
  assign blocked_s = buf_full_r & ~drain_s;
`endif

  assign accept_s     = wr_valid & wr_ready;
  assign starve_set_s = blocked_s & (starve_cnt_r >= STARVE_LIM);
  assign {mem_en, mem_we} = state_r;

  // Slot selection: the fetch path always wins, a full buffer drains into otherwise idle slots.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (rd_req) begin
      state_nxt_s = ST_RD;
    end else if (drain_s) begin
      state_nxt_s = ST_WR;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // RAM address/data registers; both hold through idle slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state_nxt_s)
        ST_RD: begin
          mem_addr <= rd_addr;
        end
        ST_WR: begin
          mem_addr  <= buf_addr_r;
          mem_wdata <= buf_data_r;
        end
        default: begin
          mem_addr  <= mem_addr;
          mem_wdata <= mem_wdata;
        end
      endcase
    end
  end

  // One-entry write buffer; drain and accept are exclusive since accept needs an empty buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_r <= 1'b0;
      wr_ready   <= 1'b1;
      buf_addr_r <= {ADDR_W{1'b0}};
      buf_data_r <= {DATA_W{1'b0}};
    end else if (drain_s) begin
      buf_full_r <= 1'b0;
      wr_ready   <= 1'b1;
    end else if (accept_s) begin
      buf_full_r <= 1'b1;
      wr_ready   <= 1'b0;
      buf_addr_r <= wr_addr;
      buf_data_r <= wr_data;
    end
  end

  // Starvation counter and sticky flag; a set condition overrides a clear at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
      starve_flag  <= 1'b0;
    end else begin
      if (drain_s) begin
        starve_cnt_r <= 4'd0;
      end else if (blocked_s && (starve_cnt_r != CNT_SAT)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
      if (starve_set_s) begin
        starve_flag <= 1'b1;
      end else if (starve_clr) begin
        starve_flag <= 1'b0;
      end
    end
  end

  // Read-return pipeline: RAM data is captured when the delayed request token reaches the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe_r  <= {(RD_LAT + 1){1'b0}};
      rd_valid_o <= 1'b0;
      rd_data_o  <= {DATA_W{1'b0}};
    end else begin
      rd_pipe_r  <= {rd_pipe_r[RD_LAT-1:0], rd_req};
      rd_valid_o <= rd_pipe_r[RD_LAT];
      if (rd_pipe_r[RD_LAT]) begin
        rd_data_o <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Testbench for fb_access_arbiter: vector table, multi-cycle corner sequences and a randomized
// phase checked against a queue-based reference model. Attaches a 1-cycle-latency RAM model.
module tb_fb_access_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          vblank;
  logic          starve_clr;
  logic          starve_flag;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;

  fb_access_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .vblank(vblank), .starve_clr(starve_clr), .starve_flag(starve_flag),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return a[11:0] ^ 12'hB9F;
  endfunction

  // RAM content is a fixed function of the address, so the read data is predictable.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram_f(mem_addr);
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          en;
    logic          we;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          rdy;
    logic          rv;
    logic [DW-1:0] rdat;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [AW-1:0] ra, input logic wv,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic en, input logic we, input logic [AW-1:0] ma,
                              input logic [DW-1:0] md, input logic rdy, input logic rv,
                              input logic [DW-1:0] rdat);
    vec_t v;
    v.rd = rd; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.en = en; v.we = we; v.ma = ma; v.md = md; v.rdy = rdy; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [44:0] obs();
    return {mem_en, mem_we, mem_addr, mem_wdata, wr_ready, rd_valid_o, rd_data_o};
  endfunction

  localparam int NV = 18;
  vec_t tbl [NV];
  logic [DW-1:0] wd [4];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rdq_t;
  rdq_t rdq [$];

  logic          m_full, m_flag, m_en, m_we, m_rv, prev_rd, drain, blocked;
  logic [AW-1:0] m_baddr, m_addr;
  logic [DW-1:0] m_bdata, m_wdata, m_rdata;
  int            m_cnt, ecount;

  initial begin
    //           rd  rd_addr   wv  wr_addr    wr_data  en  we  mem_addr   wdata    rdy rv  rdata
    tbl[0]  = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00000, 12'h000, 1, 0, 12'h000);
    tbl[1]  = mk(1, 17'h00123, 0, 17'h00000, 12'h000, 1, 0, 17'h00123, 12'h000, 1, 0, 12'h000);
    tbl[2]  = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00123, 12'h000, 1, 0, 12'h000);
    tbl[3]  = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00123, 12'h000, 1, 1, 12'hABC);
    tbl[4]  = mk(0, 17'h00000, 1, 17'h00010, 12'h0F0, 0, 0, 17'h00123, 12'h000, 0, 0, 12'hABC);
    tbl[5]  = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 1, 1, 17'h00010, 12'h0F0, 1, 0, 12'hABC);
    tbl[6]  = mk(0, 17'h00000, 1, 17'h00020, 12'h111, 0, 0, 17'h00010, 12'h0F0, 0, 0, 12'hABC);
    tbl[7]  = mk(1, 17'h00040, 0, 17'h00000, 12'h000, 1, 0, 17'h00040, 12'h0F0, 0, 0, 12'hABC);
    tbl[8]  = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 1, 1, 17'h00020, 12'h111, 1, 0, 12'hABC);
    tbl[9]  = mk(1, 17'h00041, 0, 17'h00000, 12'h000, 1, 0, 17'h00041, 12'h111, 1, 1, 12'hBDF);
    tbl[10] = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00041, 12'h111, 1, 0, 12'hBDF);
    tbl[11] = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00041, 12'h111, 1, 1, 12'hBDE);
    tbl[12] = mk(0, 17'h00000, 1, 17'h00030, 12'h222, 0, 0, 17'h00041, 12'h111, 0, 0, 12'hBDE);
    tbl[13] = mk(1, 17'h00050, 0, 17'h00000, 12'h000, 1, 0, 17'h00050, 12'h111, 0, 0, 12'hBDE);
    tbl[14] = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 1, 1, 17'h00030, 12'h222, 1, 0, 12'hBDE);
    tbl[15] = mk(1, 17'h00051, 1, 17'h00031, 12'h333, 1, 0, 17'h00051, 12'h222, 0, 1, 12'hBCF);
    tbl[16] = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 1, 1, 17'h00031, 12'h333, 1, 0, 12'hBCF);
    tbl[17] = mk(0, 17'h00000, 0, 17'h00000, 12'h000, 0, 0, 17'h00031, 12'h333, 1, 1, 12'hBCE);
    wd[0] = 12'h101; wd[1] = 12'h202; wd[2] = 12'h303; wd[3] = 12'h404;

    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    vblank = 1'b1; starve_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {obs(), starve_flag}, {2'b00, 17'h0, 12'h0, 1'b1, 1'b0, 12'h0, 1'b0});
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      tick();
      check($sformatf("table[%0d]", i), obs(),
            {tbl[i].en, tbl[i].we, tbl[i].ma, tbl[i].md, tbl[i].rdy, tbl[i].rv, tbl[i].rdat});
    end

    // Starvation: full buffer blocked by continuous reads.
    rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 17'h1ABCD; wr_data = 12'h5A5;
    tick();
    check("starve_fill", {wr_ready, starve_flag}, 2'b00);
    wr_valid = 1'b0; rd_req = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      rd_addr = 17'(32'h100 + j);
      tick();
      check($sformatf("starve_blk[%0d]", j), {wr_ready, starve_flag}, {1'b0, (j >= 15)});
    end
    rd_req = 1'b0;
    tick();
    check("starve_drain", {mem_en, mem_we, mem_addr, mem_wdata, starve_flag},
          {2'b11, 17'h1ABCD, 12'h5A5, 1'b1});
    tick();
    check("starve_sticky", starve_flag, 1'b1);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    check("starve_clr", starve_flag, 1'b0);

    // Back-to-back writes with wr_valid held: accept every other edge, order preserved.
    for (int c = 1; c <= 8; c++) begin
      wr_valid = (c <= 7);
      wr_addr  = 17'(32'h400 + (c - 1) / 2);
      wr_data  = wd[(c - 1) / 2];
      check($sformatf("b2b_ready[%0d]", c), wr_ready, (c % 2 == 1));
      tick();
      if (c % 2 == 0) begin
        check($sformatf("b2b_slot[%0d]", c), {mem_en, mem_we, mem_addr, mem_wdata},
              {2'b11, 17'(32'h400 + c / 2 - 1), wd[c / 2 - 1]});
      end else begin
        check($sformatf("b2b_acc[%0d]", c), {mem_en, wr_ready}, 2'b00);
      end
    end
    wr_valid = 1'b0;

    // Reset one cycle after a read with a write still buffered.
    wr_valid = 1'b1; wr_addr = 17'h00077; wr_data = 12'h777;
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 17'h00200;
    tick();
    rd_req = 1'b0;
    check("rst_pre", {mem_en, mem_we, wr_ready}, 3'b100);
    #2 reset = 1'b1;
    #1;
    check("rst_async", {mem_en, mem_we, wr_ready, rd_valid_o, starve_flag}, 5'b00100);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rst_after[%0d]", k), {mem_en, wr_ready, rd_valid_o, rd_data_o}, {3'b010, 12'h000});
    end

`ifdef FB_VBLANK_WR_ONLY_EN
    vblank = 1'b0; wr_valid = 1'b1; wr_addr = 17'h00999; wr_data = 12'h999;
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("vb_hold[%0d]", k), {mem_en, wr_ready}, 2'b00);
    end
    vblank = 1'b1;
    tick();
    check("vb_drain", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 17'h00999, 12'h999});
`endif

    // Randomized phase against the reference model.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_full = 1'b0; m_flag = 1'b0; m_baddr = '0; m_bdata = '0; m_addr = '0; m_wdata = '0;
    m_rdata = '0; m_cnt = 0; ecount = 0; prev_rd = 1'b0;
    rdq.delete();
    for (int c = 0; c < 1500; c++) begin
      rd_req     = !prev_rd && ($urandom_range(0, 2) == 0);
      rd_addr    = 17'($urandom);
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = 17'($urandom);
      wr_data    = 12'($urandom);
      vblank     = ($urandom_range(0, 3) != 0);
      starve_clr = ($urandom_range(0, 15) == 0);
      prev_rd    = rd_req;

`ifdef FB_VBLANK_WR_ONLY_EN
      drain   = m_full && !rd_req && vblank;
      blocked = m_full && !drain && vblank;
`else
      drain   = m_full && !rd_req;
      blocked = m_full && !drain;
`endif
      m_en = 1'b0; m_we = 1'b0;
      if (rd_req) begin
        m_en = 1'b1; m_addr = rd_addr;
        rdq.push_back('{due: ecount + 3, data: ram_f(rd_addr)});
      end else if (drain) begin
        m_en = 1'b1; m_we = 1'b1; m_addr = m_baddr; m_wdata = m_bdata;
      end
      if (drain) begin
        m_full = 1'b0;
      end else if (wr_valid && !m_full) begin
        m_full = 1'b1; m_baddr = wr_addr; m_bdata = wr_data;
      end
      if (drain) m_cnt = 0;
      else if (blocked && m_cnt < 15) m_cnt++;
      if (blocked && m_cnt >= 15) m_flag = 1'b1;
      else if (starve_clr) m_flag = 1'b0;

      tick();
      ecount++;
      m_rv = 1'b0;
      if (rdq.size() > 0 && rdq[0].due == ecount) begin
        m_rv = 1'b1; m_rdata = rdq[0].data;
        void'(rdq.pop_front());
      end
      check($sformatf("rand[%0d]", c), {obs(), starve_flag},
            {m_en, m_we, m_addr, m_wdata, !m_full, m_rv, m_rdata, m_flag});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
